// File: rtl/risc_multicycle_core_if.sv
// rtl/risc_multicycle_core_if.sv - instruction and data memory req/ack bus of the multi-cycle RISC core
interface risc_multicycle_core_if #(
    parameter int XLEN = 32,
    parameter int AW   = 16
);
    logic            imem_req;
    logic [AW-1:0]   imem_addr;
    logic [31:0]     imem_rdata;
    logic            imem_ack;
    logic            dmem_req;
    logic            dmem_we;
    logic [AW-1:0]   dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, imem_ack, dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/risc_multicycle_core.sv
// rtl/risc_multicycle_core.sv - multi-cycle RISC core, fetch/decode/exec/mem/wb FSM; RISC_MUL_EN adds R-type MUL
module risc_multicycle_core #(
    parameter int          XLEN     = 32,
    parameter int          NREG     = 32,
    parameter int          AW       = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    risc_multicycle_core_if.master mem,
    output logic                   retire,
    output logic                   halted
);
    localparam int RW = $clog2(NREG);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic [2:0]      state;
    logic [AW-1:0]   pc;
    logic [31:0]     ir;
    logic [XLEN-1:0] a, b, alu, mdr;
    logic [XLEN-1:0] regs [NREG];

    logic [5:0]      op, fn;
    logic [4:0]      sh;
    logic [RW-1:0]   rs_i, rt_i, rd_i, dst;
    logic [XLEN-1:0] imm_x, r_res;
    logic            r_ok, exec_done;

    assign op    = ir[31:26];
    assign fn    = ir[5:0];
    assign sh    = ir[10:6];
    assign rs_i  = ir[21 +: RW];
    assign rt_i  = ir[16 +: RW];
    assign rd_i  = ir[11 +: RW];
    assign imm_x = XLEN'($signed(ir[15:0]));
    assign dst   = (op == OP_R) ? rd_i : rt_i;

    always_comb begin
        r_res = '0;
        r_ok  = 1'b1;
        case (fn)
            6'h20:   r_res = a + b;
            6'h22:   r_res = a - b;
            6'h24:   r_res = a & b;
            6'h25:   r_res = a | b;
            6'h2A:   r_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            6'h00:   r_res = b << sh;
`ifdef RISC_MUL_EN
            6'h18:   r_res = a * b;
`else
`endif
            default: r_ok = 1'b0;
        endcase
    end

    // Instructions that finish in EXEC: control flow, HALT, and anything undecodable (NOP).
    always_comb begin
        case (op)
            OP_R:                   exec_done = !r_ok;
            OP_ADDI, OP_LW, OP_SW:  exec_done = 1'b0;
            default:                exec_done = 1'b1;
        endcase
    end

    assign retire = (state == S_WB)
                 || (state == S_EXEC && exec_done)
                 || (state == S_MEM && mem.dmem_req && mem.dmem_ack && mem.dmem_we);
    assign halted        = (state == S_HALT);
    assign mem.imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_FETCH;
            pc             <= AW'(RESET_PC);
            ir             <= '0;
            a              <= '0;
            b              <= '0;
            alu            <= '0;
            mdr            <= '0;
            mem.imem_req   <= 1'b0;
            mem.dmem_req   <= 1'b0;
            mem.dmem_we    <= 1'b0;
            mem.dmem_addr  <= '0;
            mem.dmem_wdata <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    // req is raised on entry to FETCH so a same-cycle ack costs no extra cycle
                    if (mem.imem_req && mem.imem_ack) begin
                        ir           <= mem.imem_rdata;
                        mem.imem_req <= 1'b0;
                        state        <= S_DECODE;
                    end else begin
                        mem.imem_req <= 1'b1;
                    end
                end
                S_DECODE: begin
                    a     <= (rs_i == '0) ? '0 : regs[rs_i];
                    b     <= (rt_i == '0) ? '0 : regs[rt_i];
                    pc    <= pc + AW'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    case (op)
                        OP_R: begin
                            if (r_ok) begin
                                alu   <= r_res;
                                state <= S_WB;
                            end else begin
                                mem.imem_req <= 1'b1;
                                state        <= S_FETCH;
                            end
                        end
                        OP_ADDI: begin
                            alu   <= a + imm_x;
                            state <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            mem.dmem_req   <= 1'b1;
                            mem.dmem_we    <= (op == OP_SW);
                            mem.dmem_addr  <= AW'(a + imm_x);
                            mem.dmem_wdata <= b;
                            state          <= S_MEM;
                        end
                        OP_BEQ: begin
                            // pc already holds PC+1 here
                            if (a == b) pc <= pc + AW'($signed(ir[15:0]));
                            mem.imem_req <= 1'b1;
                            state        <= S_FETCH;
                        end
                        OP_J: begin
                            pc           <= AW'(ir[25:0]);
                            mem.imem_req <= 1'b1;
                            state        <= S_FETCH;
                        end
                        OP_HALT: state <= S_HALT;
                        default: begin
                            mem.imem_req <= 1'b1;
                            state        <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem.dmem_ack) begin
                        mem.dmem_req <= 1'b0;
                        mem.dmem_we  <= 1'b0;
                        if (mem.dmem_we) begin
                            mem.imem_req <= 1'b1;
                            state        <= S_FETCH;
                        end else begin
                            mdr   <= mem.dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (dst != '0) regs[dst] <= (op == OP_LW) ? mdr : alu;
                    mem.imem_req <= 1'b1;
                    state        <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_risc_multicycle_core.sv
// tb/tb_risc_multicycle_core.sv - directed self-checking bench for risc_multicycle_core
module tb_risc_multicycle_core;
    logic clk;
    logic rst_n;
    logic retire;
    logic halted;

    risc_multicycle_core_if #(.XLEN(32), .AW(16)) bus ();

    risc_multicycle_core #(.XLEN(32), .NREG(32), .AW(16), .RESET_PC(0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mem    (bus.master),
        .retire (retire),
        .halted (halted)
    );

    int n_chk = 0;
    int n_fail = 0;
    int idelay = 0;
    int ddelay = 0;
    int cyc = 0;
    int icnt, dcnt;
    int dstab_err = 0;
    int istab_err = 0;
    logic [31:0] prog [256];
    logic [31:0] dmem [256];
    int          fetch_log [$];
    int          retire_cyc [$];
    logic [15:0] st_addr [$];
    logic [31:0] st_data [$];

    logic        p_dreq, p_dack, p_dwe, p_ireq, p_iack;
    logic [15:0] p_daddr, p_iaddr;
    logic [31:0] p_dwdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(int t);
        return {6'h02, 26'(t)};
    endfunction
    localparam logic [31:0] HALT = {6'h3F, 26'd0};

    // instruction memory responder
    initial begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        icnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.imem_ack = 1'b0;
                icnt = 0;
            end else if (bus.imem_ack) begin
                bus.imem_ack = 1'b0;
            end else if (bus.imem_req) begin
                if (icnt >= idelay) begin
                    bus.imem_ack = 1'b1;
                    bus.imem_rdata = prog[bus.imem_addr[7:0]];
                    fetch_log.push_back(int'(bus.imem_addr));
                    icnt = 0;
                end else icnt++;
            end
        end
    end

    // data memory responder
    initial begin
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0;
        dcnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.dmem_ack = 1'b0;
                dcnt = 0;
            end else if (bus.dmem_ack) begin
                bus.dmem_ack = 1'b0;
            end else if (bus.dmem_req) begin
                if (dcnt >= ddelay) begin
                    bus.dmem_ack = 1'b1;
                    if (bus.dmem_we) begin
                        dmem[bus.dmem_addr[7:0]] = bus.dmem_wdata;
                        st_addr.push_back(bus.dmem_addr);
                        st_data.push_back(bus.dmem_wdata);
                    end else bus.dmem_rdata = dmem[bus.dmem_addr[7:0]];
                    dcnt = 0;
                end else dcnt++;
            end
        end
    end

    // retire timestamps and request-stability tracking, sampled mid-cycle
    initial begin
        p_dreq = 0; p_dack = 0; p_dwe = 0; p_ireq = 0; p_iack = 0;
        p_daddr = 0; p_iaddr = 0; p_dwdata = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (retire) retire_cyc.push_back(cyc);
                if (bus.dmem_req && p_dreq && !p_dack &&
                    (bus.dmem_addr !== p_daddr || bus.dmem_we !== p_dwe || bus.dmem_wdata !== p_dwdata))
                    dstab_err++;
                if (bus.imem_req && p_ireq && !p_iack && bus.imem_addr !== p_iaddr)
                    istab_err++;
            end
            p_dreq = bus.dmem_req; p_dack = bus.dmem_ack; p_dwe = bus.dmem_we;
            p_daddr = bus.dmem_addr; p_dwdata = bus.dmem_wdata;
            p_ireq = bus.imem_req; p_iack = bus.imem_ack; p_iaddr = bus.imem_addr;
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            prog[i] = HALT;
            dmem[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_log.delete();
        retire_cyc.delete();
        st_addr.delete();
        st_data.delete();
        dstab_err = 0;
        istab_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input int budget, output bit timeout);
        int i;
        do_reset();
        i = 0;
        while (!halted && i < budget) begin
            @(negedge clk);
            i++;
        end
        timeout = !halted;
        @(negedge clk);
        #3;
    endtask

    task automatic test_reset();
        int i;
        clear_prog();
        prog[0] = enc_i('h08, 0, 1, 1);
        idelay = 6;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req got %b need 0", bus.imem_req); end
        n_chk++; if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0) begin n_fail++; $display("FAIL reset_dmem got req %b we %b need 0 0", bus.dmem_req, bus.dmem_we); end
        n_chk++; if (retire !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_status got retire %b halted %b need 0 0", retire, halted); end
        n_chk++; if (bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got %h need 0000", bus.imem_addr); end
        rst_n = 1'b1;
        i = 0;
        while (bus.imem_req !== 1'b1 && i < 10) begin @(negedge clk); i++; end
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL first_fetch got req %b addr %h need 1 0000", bus.imem_req, bus.imem_addr); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL midfetch_reset_req got %b need 0", bus.imem_req); end
        n_chk++; if (retire !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL midfetch_reset_status got retire %b halted %b need 0 0", retire, halted); end
        @(negedge clk);
        rst_n = 1'b1;
        i = 0;
        while (bus.imem_req !== 1'b1 && i < 10) begin @(negedge clk); i++; end
        n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin n_fail++; $display("FAIL refetch got req %b addr %h need 1 0000", bus.imem_req, bus.imem_addr); end
        n_chk++; if (fetch_log.size() != 0) begin n_fail++; $display("FAIL no_fetch_done got %0d fetches need 0", fetch_log.size()); end
        idelay = 0;
    endtask

    task automatic test_alu();
        bit to;
        logic [31:0] exp_d [7] = '{32'd2, 32'd1, 32'd8, 32'd5, 32'hFFFF_FFFD, 32'd40, 32'd0};
        logic [31:0] got;
        clear_prog();
        prog[0] = enc_i('h08, 0, 1, 5);
        prog[1] = enc_i('h08, 0, 2, -3);
        prog[2] = enc_r(1, 2, 3, 0, 'h20);
        prog[3] = enc_r(2, 1, 4, 0, 'h2A);
        prog[4] = enc_r(1, 2, 7, 0, 'h22);
        prog[5] = enc_r(1, 2, 8, 0, 'h24);
        prog[6] = enc_r(1, 2, 9, 0, 'h25);
        prog[7] = enc_r(0, 1, 10, 3, 'h00);
        prog[8] = enc_r(1, 2, 11, 0, 'h2A);
        prog[9]  = enc_i('h2B, 0, 3, 0);
        prog[10] = enc_i('h2B, 0, 4, 1);
        prog[11] = enc_i('h2B, 0, 7, 2);
        prog[12] = enc_i('h2B, 0, 8, 3);
        prog[13] = enc_i('h2B, 0, 9, 4);
        prog[14] = enc_i('h2B, 0, 10, 5);
        prog[15] = enc_i('h2B, 0, 11, 6);
        idelay = 0; ddelay = 0;
        run_prog(400, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL alu_timeout got halted %b need 1", halted); end
        for (int i = 0; i < 7; i++) begin
            got = (i < st_data.size()) ? st_data[i] : 32'hxxxx_xxxx;
            n_chk++; if (got !== exp_d[i]) begin n_fail++; $display("FAIL alu_result[%0d] got %h need %h", i, got, exp_d[i]); end
        end
        n_chk++; if (st_addr.size() != 7 || st_addr[4] !== 16'd4) begin n_fail++; $display("FAIL alu_store_count got %0d need 7", st_addr.size()); end
        n_chk++; if (retire_cyc.size() != 17) begin n_fail++; $display("FAIL alu_retires got %0d need 17", retire_cyc.size()); end
        if (retire_cyc.size() >= 10) begin
            n_chk++; if (retire_cyc[1] - retire_cyc[0] != 4) begin n_fail++; $display("FAIL alu_latency got %0d need 4", retire_cyc[1] - retire_cyc[0]); end
            n_chk++; if (retire_cyc[9] - retire_cyc[8] != 4) begin n_fail++; $display("FAIL sw_latency got %0d need 4", retire_cyc[9] - retire_cyc[8]); end
        end
    endtask

    task automatic test_mem();
        bit to;
        clear_prog();
        prog[0] = enc_i('h08, 0, 1, 5);
        prog[1] = enc_i('h2B, 0, 1, 4);
        prog[2] = enc_i('h23, 0, 5, 4);
        prog[3] = enc_i('h2B, 0, 5, 5);
        idelay = 0; ddelay = 3;
        run_prog(400, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL mem_timeout got halted %b need 1", halted); end
        n_chk++; if (st_addr.size() != 2) begin n_fail++; $display("FAIL mem_store_count got %0d need 2", st_addr.size()); end
        if (st_addr.size() == 2) begin
            n_chk++; if (st_addr[0] !== 16'd4 || st_data[0] !== 32'd5) begin n_fail++; $display("FAIL sw_access got addr %h data %h need 0004 00000005", st_addr[0], st_data[0]); end
            n_chk++; if (st_addr[1] !== 16'd5 || st_data[1] !== 32'd5) begin n_fail++; $display("FAIL lw_value got addr %h data %h need 0005 00000005", st_addr[1], st_data[1]); end
        end
        n_chk++; if (dstab_err != 0 || istab_err != 0) begin n_fail++; $display("FAIL req_held got %0d/%0d unstable samples need 0", dstab_err, istab_err); end
        n_chk++; if (retire_cyc.size() != 5) begin n_fail++; $display("FAIL mem_retires got %0d need 5", retire_cyc.size()); end
        if (retire_cyc.size() >= 3) begin
            n_chk++; if (retire_cyc[2] - retire_cyc[1] != 8) begin n_fail++; $display("FAIL lw_latency got %0d need 8", retire_cyc[2] - retire_cyc[1]); end
        end
        ddelay = 0;
    endtask

    task automatic test_branch();
        bit to;
        int exp_f [13] = '{0, 1, 2, 3, 4, 2, 3, 5, 6, 7, 16, 17, 18};
        int got;
        clear_prog();
        prog[0] = enc_i('h08, 0, 1, 0);
        prog[1] = enc_i('h08, 0, 2, 2);
        prog[2] = enc_i('h08, 1, 1, 1);
        prog[3] = enc_i('h04, 1, 2, 1);
        prog[4] = enc_j(2);
        prog[5] = enc_i('h04, 1, 0, 3);
        prog[6] = enc_i('h2B, 0, 1, 0);
        prog[7] = enc_j('h10);
        prog[8] = enc_i('h2B, 0, 0, 1);
        prog[16] = enc_i('h08, 0, 3, 7);
        prog[17] = enc_i('h2B, 0, 3, 1);
        idelay = 1; ddelay = 0;
        run_prog(600, to);
        n_chk++; if (to) begin n_fail++; $display("FAIL branch_timeout got halted %b need 1", halted); end
        n_chk++; if (fetch_log.size() != 13) begin n_fail++; $display("FAIL fetch_count got %0d need 13", fetch_log.size()); end
        for (int i = 0; i < 13; i++) begin
            got = (i < fetch_log.size()) ? fetch_log[i] : -1;
            n_chk++; if (got != exp_f[i]) begin n_fail++; $display("FAIL pc_seq[%0d] got %0d need %0d", i, got, exp_f[i]); end
        end
        n_chk++; if (st_data.size() != 2 || st_data[0] !== 32'd2 || st_data[1] !== 32'd7) begin n_fail++; $display("FAIL branch_stores got %0d stores need 2 (2,7)", st_data.size()); end
        if (retire_cyc.size() >= 4) begin
            n_chk++; if (retire_cyc[3] - retire_cyc[2] != 4) begin n_fail++; $display("FAIL beq_latency got %0d need 4", retire_cyc[3] - retire_cyc[2]); end
        end
        idelay = 0;
    endtask

    task automatic test_halt();
        bit to;
        int nreq, nret;
        clear_prog();
        prog[0] = enc_i('h08, 0, 0, 9);
        prog[1] = enc_i('h08, 0, 1, 4);
        prog[2] = 32'hF800_0000;
        prog[3] = enc_r(1, 1, 1, 0, 'h3F);
        prog[4] = enc_i('h2B, 0, 0, 0);
        prog[5] = enc_i('h2B, 0, 1, 1);
        run_prog(400, to);
        n_chk++; if (to || halted !== 1'b1) begin n_fail++; $display("FAIL halted got %b need 1", halted); end
        n_chk++; if (st_data.size() != 2 || st_data[0] !== 32'd0) begin n_fail++; $display("FAIL r0_write got %0d stores need 2 with r0=0", st_data.size()); end
        n_chk++; if (st_data.size() != 2 || st_data[1] !== 32'd4) begin n_fail++; $display("FAIL nop_no_write got %0d stores need r1=4", st_data.size()); end
        n_chk++; if (retire_cyc.size() != 7) begin n_fail++; $display("FAIL halt_retires got %0d need 7", retire_cyc.size()); end
        if (retire_cyc.size() >= 3) begin
            n_chk++; if (retire_cyc[2] - retire_cyc[1] != 3) begin n_fail++; $display("FAIL nop_latency got %0d need 3", retire_cyc[2] - retire_cyc[1]); end
        end
        nreq = 0; nret = 0;
        repeat (20) begin
            @(negedge clk);
            #2;
            if (bus.imem_req || bus.dmem_req) nreq++;
            if (retire) nret++;
        end
        n_chk++; if (nreq != 0 || nret != 0) begin n_fail++; $display("FAIL post_halt got %0d req %0d retire cycles need 0 0", nreq, nret); end
        rst_n = 1'b0;
        #1;
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_cleared got %b need 0", halted); end
    endtask

    task automatic test_mul();
        bit to;
        logic [31:0] exp;
`ifdef RISC_MUL_EN
        exp = 32'hFFFF_FFF1;
`else
        exp = 32'd1;
`endif
        clear_prog();
        prog[0] = enc_i('h08, 0, 1, 5);
        prog[1] = enc_i('h08, 0, 2, -3);
        prog[2] = enc_i('h08, 0, 6, 1);
        prog[3] = enc_r(1, 2, 6, 0, 'h18);
        prog[4] = enc_i('h2B, 0, 6, 0);
        run_prog(400, to);
        n_chk++; if (to || st_data.size() != 1 || st_data[0] !== exp) begin n_fail++; $display("FAIL mul_result got %0d stores halted %b need r6=%h", st_data.size(), halted, exp); end
        n_chk++; if (retire_cyc.size() != 6) begin n_fail++; $display("FAIL mul_retires got %0d need 6", retire_cyc.size()); end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_halt();
        test_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
